// File: rtl/seq_shifter_if.sv
// Request/result handshake bundle for the multi-cycle shift/rotate unit.
// master drives requests and accepts results; slave is the shifter itself.
interface seq_shifter_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [AMT_W-1:0] in_amt;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_cf;
    logic             out_zf;
    logic             out_err;
    logic             busy;

    modport master (
        output in_valid, in_data, in_amt, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_cf, out_zf, out_err, busy
    );

    modport slave (
        input  in_valid, in_data, in_amt, in_op, out_ready,
        output in_ready, out_valid, out_data, out_cf, out_zf, out_err, busy
    );
endinterface

// File: rtl/seq_shifter.sv
// Multi-cycle shift/rotate unit: moves STEP bits per clock through IDLE/SHIFT/DONE,
// reporting carry, zero and illegal-op flags with valid/ready on both sides.
module seq_shifter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned STEP  = 1,
    parameter int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_shifter_if.slave bus
);

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_ROL = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [2:0]       op_q;
    logic             sign_q;
    logic [AMT_W-1:0] rem_q;
    logic [WIDTH-1:0] data_q;
    logic             cf_q;
    logic             zf_q;
    logic             err_q;

    logic             accept;
    logic [AMT_W-1:0] eff;
    logic             illegal;
    logic [AMT_W-1:0] step_amt;
    logic [WIDTH-1:0] shift_data;
    logic             shift_cf;

    assign accept = (state == IDLE) && bus.in_valid;

    // Effective amount: shifts saturate at WIDTH, rotates wrap modulo WIDTH
    always_comb begin
        eff     = '0;
        illegal = 1'b0;
        case (bus.in_op)
            OP_SLL, OP_SRL, OP_SRA:
                eff = (bus.in_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : bus.in_amt;
            OP_ROL, OP_ROR:
                eff = bus.in_amt % AMT_W'(WIDTH);
            default:
                illegal = 1'b1;
        endcase
    end

    assign step_amt = (rem_q < AMT_W'(STEP)) ? rem_q : AMT_W'(STEP);

    // One clock's worth of single-bit moves; the carry tracks the last bit out
    always_comb begin
        shift_data = data_q;
        shift_cf   = cf_q;
        for (int i = 0; i < int'(STEP); i++) begin
            if (AMT_W'(i) < step_amt) begin
                case (op_q)
                    OP_SLL: begin
                        shift_cf   = shift_data[WIDTH-1];
                        shift_data = {shift_data[WIDTH-2:0], 1'b0};
                    end
                    OP_SRL: begin
                        shift_cf   = shift_data[0];
                        shift_data = {1'b0, shift_data[WIDTH-1:1]};
                    end
                    OP_SRA: begin
                        shift_cf   = shift_data[0];
                        shift_data = {sign_q, shift_data[WIDTH-1:1]};
                    end
                    OP_ROL: begin
                        shift_cf   = shift_data[WIDTH-1];
                        shift_data = {shift_data[WIDTH-2:0], shift_data[WIDTH-1]};
                    end
                    OP_ROR: begin
                        shift_cf   = shift_data[0];
                        shift_data = {shift_data[0], shift_data[WIDTH-1:1]};
                    end
                    default: begin
                        shift_cf   = cf_q;
                        shift_data = data_q;
                    end
                endcase
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    state_nxt = (eff == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (rem_q == step_amt) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State-decoded handshake outputs
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE:    bus.in_ready  = 1'b1;
            SHIFT:   bus.busy      = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                bus.busy      = 1'b1;
            end
            default: bus.in_ready  = 1'b0;
        endcase
    end

    // Working/result registers; values persist after the result handshake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q   <= 3'b000;
            sign_q <= 1'b0;
            rem_q  <= '0;
            data_q <= '0;
            cf_q   <= 1'b0;
            zf_q   <= 1'b0;
            err_q  <= 1'b0;
        end else if (accept) begin
            op_q   <= bus.in_op;
            sign_q <= bus.in_data[WIDTH-1];
            rem_q  <= eff;
            data_q <= bus.in_data;
            cf_q   <= 1'b0;
            zf_q   <= (bus.in_data == '0);
            err_q  <= illegal;
        end else if (state == SHIFT) begin
            rem_q  <= rem_q - step_amt;
            data_q <= shift_data;
            cf_q   <= shift_cf;
            zf_q   <= (shift_data == '0);
        end
    end

    assign bus.out_data = data_q;
    assign bus.out_cf   = cf_q;
    assign bus.out_zf   = zf_q;
    assign bus.out_err  = err_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Directed bench for seq_shifter: one 8-bit/STEP=1 and one 16-bit/STEP=4 instance.
module tb_seq_shifter;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    seq_shifter_if #(.WIDTH(8))  a ();
    seq_shifter_if #(.WIDTH(16)) b ();

    seq_shifter #(.WIDTH(8), .STEP(1)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a.slave)
    );

    seq_shifter #(.WIDTH(16), .STEP(4)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // {busy, in_ready, out_valid, err, zf, cf, data[15:0]}
    function automatic logic [21:0] obs(input bit sel);
        if (sel)
            return {b.busy, b.in_ready, b.out_valid, b.out_err, b.out_zf, b.out_cf, b.out_data};
        else
            return {a.busy, a.in_ready, a.out_valid, a.out_err, a.out_zf, a.out_cf, 8'h00, a.out_data};
    endfunction

    task automatic drive(input bit sel, input logic valid, input logic [2:0] op,
                         input logic [15:0] data, input logic [4:0] amt);
        if (sel) begin
            b.in_valid = valid; b.in_op = op; b.in_data = data; b.in_amt = amt;
        end else begin
            a.in_valid = valid; a.in_op = op; a.in_data = data[7:0]; a.in_amt = amt[3:0];
        end
    endtask

    task automatic run(input bit sel, input string tag, input logic [2:0] op,
                       input logic [15:0] data, input logic [4:0] amt,
                       input logic [15:0] exp_d, input logic exp_cf, input logic exp_zf,
                       input logic exp_err, input int exp_lat, input int hold);
        int          lat;
        logic [21:0] snap;
        drive(sel, 1'b1, op, data, amt);
        @(posedge clk); #1;
        drive(sel, 1'b0, 3'b000, 16'h0000, 5'd0);
        lat = 0;
        while (!obs(sel)[19] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, 32'(obs(sel)[15:0]), 32'(exp_d));
        check({tag, "_flags"}, 32'(obs(sel)[18:16]), 32'({exp_err, exp_zf, exp_cf}));
        check({tag, "_ready"}, 32'(obs(sel)[20]), 32'd0);
        snap = obs(sel);
        if (hold > 0) drive(sel, 1'b1, 3'b001, ~data, 5'd1);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold"}, 32'(obs(sel)), 32'(snap));
        end
        drive(sel, 1'b0, 3'b000, 16'h0000, 5'd0);
        if (sel) b.out_ready = 1'b1; else a.out_ready = 1'b1;
        @(posedge clk); #1;
        a.out_ready = 1'b0;
        b.out_ready = 1'b0;
        check({tag, "_idle"}, 32'(obs(sel)[21:19]), 32'b010);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        drive(1'b0, 1'b0, 3'b000, 16'h0000, 5'd0);
        drive(1'b1, 1'b0, 3'b000, 16'h0000, 5'd0);
        a.out_ready = 1'b0;
        b.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst8", 32'(obs(1'b0)), 32'h10_0000);
        check("rst16", 32'(obs(1'b1)), 32'h10_0000);
        rst_n = 1'b1;
        @(posedge clk); #1;

        //   sel   tag        op      data      amt    exp_d    cf    zf    err   lat hold
        run(1'b0, "sll81",   3'b000, 16'h0081, 5'd1,  16'h02,   1'b1, 1'b0, 1'b0, 1, 0);
        run(1'b0, "rorb4",   3'b100, 16'h00B4, 5'd11, 16'h96,   1'b1, 1'b0, 1'b0, 3, 0);
        run(1'b0, "sra80",   3'b010, 16'h0080, 5'd12, 16'hFF,   1'b1, 1'b0, 1'b0, 8, 0);
        run(1'b0, "srl01",   3'b001, 16'h0001, 5'd1,  16'h00,   1'b1, 1'b1, 1'b0, 1, 0);
        run(1'b0, "sll_sat", 3'b000, 16'h0001, 5'd8,  16'h00,   1'b1, 1'b1, 1'b0, 8, 0);
        run(1'b0, "srl_sat", 3'b001, 16'h0080, 5'd9,  16'h00,   1'b1, 1'b1, 1'b0, 8, 0);
        run(1'b0, "rol_w",   3'b011, 16'h00A5, 5'd8,  16'hA5,   1'b0, 1'b0, 1'b0, 0, 0);
        run(1'b0, "hold",    3'b000, 16'h000F, 5'd2,  16'h3C,   1'b0, 1'b0, 1'b0, 2, 5);
        run(1'b0, "illegal", 3'b110, 16'h005A, 5'd3,  16'h5A,   1'b0, 1'b0, 1'b1, 0, 0);
        run(1'b0, "legal2",  3'b001, 16'h00F0, 5'd4,  16'h0F,   1'b0, 1'b0, 1'b0, 4, 0);
        run(1'b1, "rol1234", 3'b011, 16'h1234, 5'd5,  16'h4682, 1'b0, 1'b0, 1'b0, 2, 0);
        run(1'b1, "amt0",    3'b011, 16'h1234, 5'd0,  16'h1234, 1'b0, 1'b0, 1'b0, 0, 0);
        run(1'b1, "sra16",   3'b010, 16'h8001, 5'd6,  16'hFE00, 1'b0, 1'b0, 1'b0, 2, 0);

        // Reset mid-SHIFT discards the request
        drive(1'b0, 1'b1, 3'b000, 16'h00FF, 5'd7);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 3'b000, 16'h0000, 5'd0);
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_busy", 32'(a.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst", 32'(obs(1'b0)), 32'h10_0000);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst", 32'(obs(1'b0)), 32'h10_0000);
        run(1'b0, "after_rst", 3'b000, 16'h0003, 5'd7, 16'h80, 1'b1, 1'b0, 1'b0, 7, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
